// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  // Warning window: minutes at zero, seconds in (00, warn_ss]; BCD compares like binary.
  function automatic logic in_warn_window(input logic [7:0] mm, input logic [7:0] ss,
                                          input logic [7:0] warn_ss);
    return (mm == 8'h00) && (ss != 8'h00) && (ss <= warn_ss);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit; borrow chains to the next more significant digit.
module bcd_digit_down #(
  parameter logic [3:0] MAX  = 4'd9,
  parameter logic [3:0] INIT = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       en,
  output logic [3:0] q,
  output logic       borrow
);

  assign borrow = en && (q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= INIT;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: preset select, prescaled tick, start/pause/abort FSM,
// done pulse, warning flag and valve drive.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int                      CLK_HZ    = 50_000_000,
  parameter int                      TICK_HZ   = 1,
  parameter int                      NUM_MODES = 4,
  parameter logic [NUM_MODES*16-1:0] PRESETS   = {16'h0500, 16'h1000, 16'h3959, 16'h1459},
  parameter logic [7:0]              WARN_SS   = 8'h10,
  localparam int                     MW        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [MW-1:0] mode,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  output logic [3:0]    Dmin,
  output logic [3:0]    Umin,
  output logic [3:0]    Dseg,
  output logic [3:0]    Useg,
  output logic          running,
  output logic          valve_on,
  output logic          done,
  output logic          warn
);

  localparam int             DIV  = CLK_HZ / TICK_HZ;
  localparam int             PW   = $clog2(DIV);
  localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

  state_t        state, state_n;
  logic [PW-1:0] presc;
  logic [15:0]   preset;
  logic          zero, underflow, accept_start, load, advance, tick;
  logic          b_useg, b_dseg, b_umin;

  // Out-of-range mode values fall through to preset 0.
  always_comb begin
    preset = PRESETS[15:0];
    for (int unsigned i = 1; i < NUM_MODES; i++) begin
      if (mode == MW'(i)) preset = PRESETS[i*16 +: 16];
    end
  end

  always_comb begin
    zero         = ({Dmin, Umin, Dseg, Useg} == '0);
    accept_start = !abort && start && (state == IDLE || state == DONE);
    load         = (state == IDLE) || accept_start;
    // Releasing pause resumes counting on the same edge so the tick phase is kept.
    advance      = !abort && !pause && ((state == RUN && !zero) || state == PAUSE);
    tick         = advance && (presc == LAST);
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_n = RUN;
        RUN: begin
          if (zero || underflow) state_n = DONE;
          else if (pause)        state_n = PAUSE;
        end
        PAUSE:   if (!pause) state_n = RUN;
        DONE:    if (start) state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      running  <= 1'b0;
      valve_on <= 1'b0;
      done     <= 1'b0;
      warn     <= 1'b0;
    end else begin
      state <= state_n;
      if (abort || accept_start) begin
        presc <= '0;
      end else if (advance) begin
        presc <= tick ? '0 : presc + PW'(1);
      end
      running  <= (state_n == RUN);
      valve_on <= (state_n == RUN) || (state_n == PAUSE);
      done     <= (state == RUN) && (state_n == DONE);
      warn     <= (state_n != IDLE) && in_warn_window({Dmin, Umin}, {Dseg, Useg}, WARN_SS);
    end
  end

  bcd_digit_down #(.MAX(BCD_MAX_UNITS), .INIT(PRESETS[3:0])) u_useg (
    .clk(clk), .reset(reset), .load(load), .d(preset[3:0]), .en(tick),
    .q(Useg), .borrow(b_useg)
  );

  bcd_digit_down #(.MAX(BCD_MAX_TENS), .INIT(PRESETS[7:4])) u_dseg (
    .clk(clk), .reset(reset), .load(load), .d(preset[7:4]), .en(b_useg),
    .q(Dseg), .borrow(b_dseg)
  );

  bcd_digit_down #(.MAX(BCD_MAX_UNITS), .INIT(PRESETS[11:8])) u_umin (
    .clk(clk), .reset(reset), .load(load), .d(preset[11:8]), .en(b_dseg),
    .q(Umin), .borrow(b_umin)
  );

  bcd_digit_down #(.MAX(BCD_MAX_UNITS), .INIT(PRESETS[15:12])) u_dmin (
    .clk(clk), .reset(reset), .load(load), .d(preset[15:12]), .en(b_umin),
    .q(Dmin), .borrow(underflow)
  );

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized + directed bench for bcd_countdown_timer against a seconds-based reference model.
module tb_bcd_countdown_timer;

  localparam int               NM  = 5;
  localparam logic [NM*16-1:0] PRE = {16'h0000, 16'h0003, 16'h1000, 16'h3959, 16'h1459};

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [2:0] mode;
  logic [3:0] Dmin, Umin, Dseg, Useg;
  logic       running, valve_on, done, warn;
  logic [15:0] digits;

  assign digits = {Dmin, Umin, Dseg, Useg};

  bcd_countdown_timer #(
    .CLK_HZ(4), .TICK_HZ(1), .NUM_MODES(NM), .PRESETS(PRE), .WARN_SS(8'h10)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .pause(pause), .abort(abort),
    .Dmin(Dmin), .Umin(Umin), .Dseg(Dseg), .Useg(Useg),
    .running(running), .valve_on(valve_on), .done(done), .warn(warn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining time in plain seconds, tick phase in cycles.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
  int   preset_secs [8] = '{899, 2399, 600, 3, 0, 899, 899, 899};
  mst_t ms;
  int   secs, phase;
  bit   e_run, e_valve, e_done, e_warn;

  function automatic logic [15:0] to_bcd(input int s);
    int mm = s / 60;
    int ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    ms = M_IDLE; secs = 899; phase = 0;
    e_run = 0; e_valve = 0; e_done = 0; e_warn = 0;
  endtask

  task automatic model_step();
    mst_t n   = ms;
    int   s   = secs;
    int   pre = preset_secs[mode];
    bit   adv = 0;
    e_done = 0;
    if (ms == M_IDLE) s = pre;
    if (abort) begin
      n = M_IDLE; phase = 0;
    end else begin
      case (ms)
        M_IDLE:  if (start) begin n = M_RUN; phase = 0; end
        M_RUN: begin
          if (secs == 0)  begin n = M_DONE; e_done = 1; end
          else if (pause) n = M_PAUSE;
          else            adv = 1;
        end
        M_PAUSE: if (!pause) begin n = M_RUN; adv = 1; end
        M_DONE:  if (start) begin n = M_RUN; s = pre; phase = 0; end
        default: n = M_IDLE;
      endcase
    end
    if (adv) begin
      phase++;
      if (phase == 4) begin phase = 0; s--; end
    end
    e_warn  = (n != M_IDLE) && secs >= 1 && secs <= 10;
    e_run   = (n == M_RUN);
    e_valve = (n == M_RUN) || (n == M_PAUSE);
    ms = n; secs = s;
  endtask

  task automatic compare_all();
    check_eq("digits", digits, to_bcd(secs));
    check_eq("running", running, e_run);
    check_eq("valve_on", valve_on, e_valve);
    check_eq("done", done, e_done);
    check_eq("warn", warn, e_warn);
    check_eq("bcd_valid", (Useg <= 9 && Dseg <= 5 && Umin <= 9 && Dmin <= 9), 1);
  endtask

  task automatic cycle(input bit st, input bit ab, input bit pa, input logic [2:0] md);
    start = st; abort = ab; pause = pa; mode = md;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  int done_cnt;
  bit pa_r;

  initial begin
    reset = 1'b1; start = 0; pause = 0; abort = 0; mode = 0;
    model_reset();
    #12;
    compare_all();
    check_eq("reset_digits", digits, 16'h1459);
    @(negedge clk);
    reset = 1'b0;

    // Mode 0 start, first tick after DIV cycles
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_eq("t1_load", digits, 16'h1459);
    check_eq("t1_running", running, 1);
    repeat (4) cycle(0, 0, 0, 0);
    check_eq("t1_tick", digits, 16'h1458);
    cycle(0, 1, 0, 0);

    // 10:00 full borrow chain
    cycle(0, 0, 0, 2);
    cycle(1, 0, 0, 2);
    repeat (4) cycle(0, 0, 0, 2);
    check_eq("t2_borrow", digits, 16'h0959);
    repeat (4) cycle(0, 0, 0, 2);
    check_eq("t2_next", digits, 16'h0958);
    cycle(0, 1, 0, 2);

    // 00:03 to completion, single done pulse
    cycle(0, 0, 0, 3);
    cycle(1, 0, 0, 3);
    done_cnt = 0;
    repeat (20) begin
      cycle(0, 0, 0, 3);
      if (done) done_cnt++;
    end
    check_eq("t3_done_pulses", 16'(done_cnt), 1);
    check_eq("t3_valve_off", valve_on, 0);
    check_eq("t3_zero", digits, 16'h0000);
    cycle(1, 0, 0, 3);
    check_eq("t3_restart", digits, 16'h0003);
    cycle(0, 1, 0, 3);

    // Pause mid-period then resume
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    repeat (10) cycle(0, 0, 1, 0);
    check_eq("t4_frozen", digits, 16'h1459);
    repeat (2) cycle(0, 0, 0, 0);
    check_eq("t4_resume_tick", digits, 16'h1458);

    // Mode change ignored while running, picked up in IDLE
    repeat (8) cycle(0, 0, 0, 1);
    check_eq("t5_mode_ignored", digits, 16'h1456);
    cycle(0, 1, 0, 1);
    repeat (2) cycle(0, 0, 0, 1);
    check_eq("t5_idle_preset", digits, 16'h3959);

    // abort wins over start; zero preset and out-of-range mode
    cycle(1, 1, 0, 1);
    check_eq("t6_abort_start", running, 0);
    cycle(0, 0, 0, 4);
    cycle(1, 0, 0, 4);
    cycle(0, 0, 1, 4);
    check_eq("t6_zero_done", done, 1);
    cycle(0, 1, 0, 6);
    repeat (2) cycle(0, 0, 0, 6);
    check_eq("t6_mode_wrap", digits, 16'h1459);

    // Async reset in the middle of a run
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 1);
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_running", running, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_digits", digits, 16'h1459);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    pa_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) pa_r = ~pa_r;
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0, pa_r,
            3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
